// File: rtl/series_acc_pkg.sv
// Shared types and constants for the arithmetic-series engine.
package series_acc_pkg;

   // Controller states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Term transform selected by the mode input
   localparam logic MODE_SUM = 1'b0;
   localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/series_acc_ctrl.sv
// Control FSM for series_accumulator: accepts starts, sequences accumulation and
// raises the finish strobe once the running term has passed the upper bound.
module series_acc_ctrl
   import series_acc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_step_zero,
   input  logic i_term_gt_last,
   output logic o_load,
   output logic o_acc_en,
   output logic o_finish
);

   state_e r_state;
   state_e w_state_next;

   // State register; async active-low reset returns to idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a zero step skips accumulation and reports at once
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StDone: begin
            if (i_start) begin
               w_state_next = i_step_zero ? StDone : StAcc;
            end
         end
         StAcc: begin
            if (i_term_gt_last) begin
               w_state_next = StDone;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Strobe decode; start is ignored while accumulating
   always_comb begin
      o_load   = 1'b0;
      o_acc_en = 1'b0;
      o_finish = 1'b0;
      unique case (r_state)
         StIdle, StDone: o_load = i_start;
         StAcc: begin
            o_acc_en = ~i_term_gt_last;
            o_finish = i_term_gt_last;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/series_accumulator.sv
// Arithmetic-series engine: sums first, first+step, ... <= last, either as plain
// terms or as squares, one term per cycle, with done/overflow/error status.
module series_accumulator
   import series_acc_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned SUM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [CNT_W-1:0] i_first,
   input  logic [CNT_W-1:0] i_last,
   input  logic [CNT_W-1:0] i_step,
   output logic             o_busy,
   output logic             o_done,
   output logic [SUM_W-1:0] o_result,
   output logic             o_ovf,
   output logic             o_err
);

   // The full square of the largest term must fit in the accumulator
   if (SUM_W < 2 * CNT_W) begin : g_width_check
      $error("series_accumulator: SUM_W must be at least 2*CNT_W");
   end

   logic             r_mode;
   logic [CNT_W-1:0] r_last;
   logic [CNT_W-1:0] r_step;
   // One extra bit so term+step can exceed last without wrapping back below it
   logic [CNT_W:0]   r_term;
   logic [SUM_W-1:0] r_sum;
   logic [SUM_W-1:0] r_result;
   logic             r_busy;
   logic             r_done;
   logic             r_ovf;
   logic             r_err;

   logic             w_load;
   logic             w_acc_en;
   logic             w_finish;
   logic             w_step_zero;
   logic             w_term_gt_last;
   logic [CNT_W-1:0] w_term_lo;
   logic [2*CNT_W-1:0] w_square;
   logic [SUM_W-1:0] w_addend;
   logic [SUM_W:0]   w_sum_next;

   assign w_step_zero    = (i_step == '0);
   assign w_term_gt_last = (r_term > {1'b0, r_last});

   // While accumulating, term <= last so the low bits hold the whole term
   assign w_term_lo  = r_term[CNT_W-1:0];
   assign w_square   = w_term_lo * w_term_lo;
   assign w_addend   = (r_mode == MODE_SQR) ? SUM_W'(w_square) : SUM_W'(w_term_lo);
   assign w_sum_next = {1'b0, r_sum} + {1'b0, w_addend};

   series_acc_ctrl u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_step_zero   (w_step_zero),
      .i_term_gt_last(w_term_gt_last),
      .o_load        (w_load),
      .o_acc_en      (w_acc_en),
      .o_finish      (w_finish)
   );

   // Run parameters captured on an accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= MODE_SUM;
         r_last <= '0;
         r_step <= '0;
      end else if (w_load) begin
         r_mode <= i_mode;
         r_last <= i_last;
         r_step <= i_step;
      end
   end

   // Term counter and running sum; the carry out of the sum is sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_term <= '0;
         r_sum  <= '0;
         r_ovf  <= 1'b0;
      end else if (w_load) begin
         r_term <= {1'b0, i_first};
         r_sum  <= '0;
         r_ovf  <= 1'b0;
      end else if (w_acc_en) begin
         r_term <= r_term + {1'b0, r_step};
         r_sum  <= w_sum_next[SUM_W-1:0];
         r_ovf  <= r_ovf | w_sum_next[SUM_W];
      end
   end

   // Status and result registers, held stable in the done state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_load) begin
         r_result <= '0;
         r_busy   <= ~w_step_zero;
         r_done   <= w_step_zero;
         r_err    <= w_step_zero;
      end else if (w_finish) begin
         r_result <= r_sum;
         r_busy   <= 1'b0;
         r_done   <= 1'b1;
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;
   assign o_ovf    = r_ovf;
   assign o_err    = r_err;

endmodule

// File: tb/tb_series_accumulator.sv
// Bench for series_accumulator: two instances (32-bit and 16-bit sums) share
// inputs; a driver pushes model results into per-instance queues and a monitor
// pops and compares them whenever an instance presents a fresh done.
module tb_series_accumulator;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  start;
   logic        mode;
   logic [7:0]  first;
   logic [7:0]  last;
   logic [7:0]  step;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [1:0]  ovf;
   logic [1:0]  err;
   logic [31:0] res_a;
   logic [15:0] res_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_tests;
   int   n_fail;
   int   n_comp[2];

   // Monitor state
   logic       st_prev[2];
   logic       busy_prev[2];
   logic       done_prev[2];
   logic       rst_prev;
   int         cnt[2];
   int         bcnt[2];
   logic       m_acc;
   logic       m_have;
   exp_t       m_e;
   logic [31:0] m_r;

   series_accumulator #(.CNT_W(8), .SUM_W(32)) u_dut_a (
      .clk(clk), .rst(rst), .i_start(start[0]), .i_mode(mode),
      .i_first(first), .i_last(last), .i_step(step),
      .o_busy(busy[0]), .o_done(done[0]), .o_result(res_a), .o_ovf(ovf[0]), .o_err(err[0])
   );

   series_accumulator #(.CNT_W(8), .SUM_W(16)) u_dut_b (
      .clk(clk), .rst(rst), .i_start(start[1]), .i_mode(mode),
      .i_first(first), .i_last(last), .i_step(step),
      .o_busy(busy[1]), .o_done(done[1]), .o_result(res_b), .o_ovf(ovf[1]), .o_err(err[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: walk the series with plain integer arithmetic
   function automatic exp_t model(logic m, logic [7:0] f, logic [7:0] l, logic [7:0] s,
                                  int sw);
      exp_t   e;
      longint sum;
      int     n;
      sum = 0;
      n   = 0;
      if (s == 0) begin
         e.res = 0; e.ovf = 1'b0; e.err = 1'b1; e.lat = 0;
      end else begin
         for (int t = int'(f); t <= int'(l); t += int'(s)) begin
            sum += m ? longint'(t * t) : longint'(t);
            n++;
         end
         e.res = 32'(sum % (longint'(1) << sw));
         e.ovf = (sum >= (longint'(1) << sw));
         e.err = 1'b0;
         e.lat = n + 1;
      end
      return e;
   endfunction

   task automatic check(int d, string name, longint act, longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0d, expected %0d", d, name, act, req);
      end
   endtask

   task automatic issue(int d, logic m, logic [7:0] f, logic [7:0] l, logic [7:0] s,
                        bit push);
      exp_t e;
      e = model(m, f, l, s, (d == 0) ? 32 : 16);
      @(posedge clk); #1;
      mode = m; first = f; last = l; step = s;
      start[d] = 1'b1;
      if (push) begin
         if (d == 0) q_a.push_back(e);
         else        q_b.push_back(e);
      end
      @(posedge clk); #1;
      start[d] = 1'b0;
      mode  = 1'($urandom);
      first = 8'($urandom);
      last  = 8'($urandom);
      step  = 8'($urandom);
   endtask

   task automatic wait_done(int d, int c0);
      for (int i = 0; i < 600 && n_comp[d] == c0; i++) @(posedge clk);
      n_tests++;
      if (n_comp[d] == c0) begin
         n_fail++;
         $display("FAIL dut%0d completion timeout: got no done, expected done", d);
      end
   endtask

   task automatic run(int d, logic m, logic [7:0] f, logic [7:0] l, logic [7:0] s);
      int c0;
      c0 = n_comp[d];
      issue(d, m, f, l, s, 1'b1);
      wait_done(d, c0);
   endtask

   initial begin
      int  c0;
      int  sel;
      logic [7:0] rs;
      n_tests = 0; n_fail = 0;
      n_comp[0] = 0; n_comp[1] = 0;
      for (int d = 0; d < 2; d++) begin
         st_prev[d] = 1'b0; busy_prev[d] = 1'b0; done_prev[d] = 1'b0;
         cnt[d] = 0; bcnt[d] = 0;
      end
      rst_prev = 1'b0;
      start = 2'b00; mode = 1'b0; first = '0; last = '0; step = '0;
      rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               m_acc = st_prev[d] && !busy_prev[d] && rst_prev && rst;
               if (m_acc) begin
                  cnt[d]  = 0;
                  bcnt[d] = busy[d] ? 1 : 0;
               end else begin
                  cnt[d]++;
                  if (busy[d]) bcnt[d]++;
               end
               if (rst && done[d] && (!done_prev[d] || m_acc)) begin
                  n_comp[d]++;
                  m_have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
                  if (!m_have) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL dut%0d unexpected done: got done=1, expected no run", d);
                  end else begin
                     if (d == 0) m_e = q_a.pop_front();
                     else        m_e = q_b.pop_front();
                     m_r = (d == 0) ? res_a : {16'h0, res_b};
                     check(d, "result", m_r, m_e.res);
                     check(d, "ovf", ovf[d], m_e.ovf);
                     check(d, "err", err[d], m_e.err);
                     check(d, "latency", cnt[d], m_e.lat);
                     check(d, "busy_cycles", bcnt[d], m_e.err ? 0 : m_e.lat);
                  end
               end
               st_prev[d]   = start[d];
               busy_prev[d] = busy[d];
               done_prev[d] = done[d];
            end
            rst_prev = rst;
         end
      join_none

      // Reset state
      #1;
      check(0, "reset busy", busy[0], 0);
      check(0, "reset done", done[0], 0);
      check(0, "reset result", res_a, 0);
      check(0, "reset ovf", ovf[0], 0);
      check(0, "reset err", err[0], 0);
      check(1, "reset done", done[1], 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run(0, 1'b0, 8'd1,   8'd100, 8'd1);
      run(0, 1'b1, 8'd1,   8'd10,  8'd1);
      run(0, 1'b0, 8'd1,   8'd100, 8'd3);
      run(0, 1'b0, 8'd10,  8'd5,   8'd1);
      run(0, 1'b0, 8'd1,   8'd100, 8'd0);
      run(0, 1'b0, 8'd7,   8'd9,   8'd0);
      run(1, 1'b1, 8'd0,   8'd255, 8'd1);
      run(0, 1'b0, 8'd255, 8'd255, 8'd255);
      run(1, 1'b0, 8'd1,   8'd100, 8'd1);
      run(0, 1'b1, 8'd0,   8'd255, 8'd1);

      // Start during accumulation is ignored
      c0 = n_comp[0];
      issue(0, 1'b0, 8'd1, 8'd100, 8'd1, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      start[0] = 1'b1; mode = 1'b1; first = 8'd0; last = 8'd255; step = 8'd1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      wait_done(0, c0);

      // Reset mid-run aborts immediately
      issue(0, 1'b1, 8'd0, 8'd200, 8'd1, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check(0, "abort busy", busy[0], 0);
      check(0, "abort done", done[0], 0);
      check(0, "abort result", res_a, 0);
      check(0, "abort ovf", ovf[0], 0);
      check(0, "abort err", err[0], 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run(0, 1'b0, 8'd1, 8'd100, 8'd1);

      // Randomized runs on both instances
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)     rs = 8'd0;
         else if (sel < 5) rs = 8'($urandom_range(1, 4));
         else              rs = 8'($urandom_range(1, 255));
         run(i % 2, 1'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rs);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
